// File: rtl/iru_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : iru_seq_ctrl
// Purpose  : Sequencer for the image rotation unit datapath. Accepts one
//            DIM x DIM image plus a rotation word from the RNN stage, clears
//            the output buffer, sweeps the input buffer for LANE_LEN cycles
//            while driving per-lane source coordinates and write strobes, then
//            holds the rotated image until the BCAU stage takes it.
// Ports    : clk, rst (async, active-high)
//            rnn_out_ready / rnn_out      - job offer and rotation word
//            bcau_in_ready                - downstream take of rotated image
//            in_ready / out_ready         - job accept / result valid
//            angle_q                      - latched rotation word
//            write_in, rotate_in          - input buffer load / advance
//            zero_out, write_out          - output buffer clear / write
//            row_sel, col_sel             - per-lane source coordinates
//            busy                         - sequencer not idle
// Revision : 1.0 - initial release
// ============================================================================
module iru_seq_ctrl #(
  parameter int LANES    = 5,
  parameter int LANE_LEN = 80,
  parameter int DIM      = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rnn_out_ready,
  input  logic [35:0]           rnn_out,
  input  logic                  bcau_in_ready,
  output logic                  in_ready,
  output logic                  out_ready,
  output logic [35:0]           angle_q,
  output logic                  write_in,
  output logic                  rotate_in,
  output logic                  zero_out,
  output logic                  write_out,
  output logic [LANES-1:0][4:0] row_sel,
  output logic [LANES-1:0][4:0] col_sel,
  output logic                  busy
);

  // Each lane owns ROWS_PER_LANE consecutive image rows.
  localparam int SEL_W         = 5;
  localparam int ROWS_PER_LANE = LANE_LEN / DIM;
  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(DIM - 1);
  localparam logic [SEL_W-1:0] R_LAST = SEL_W'(ROWS_PER_LANE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ZERO  = 2'd1,
    S_SWEEP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [SEL_W-1:0] c;          // k % DIM
  logic [SEL_W-1:0] r;          // k / DIM
  logic             accept;
  logic             sweep_en;
  logic             sweep_last;

  assign sweep_last = (c == C_LAST) && (r == R_LAST);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Rotation word latch: only loads on an accepted job, so it stays stable
  // for the compute lanes through the whole sweep and the DONE hold.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q <= '0;
    end else if (accept) begin
      angle_q <= rnn_out;
    end
  end

  // --------------------------------------------------------------------------
  // Sweep step held as column/row sub-counters so no divider is needed.
  // Counters return to zero on the last step and whenever not sweeping.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c <= '0;
      r <= '0;
    end else if (state == S_SWEEP) begin
      if (c == C_LAST) begin
        c <= '0;
        r <= sweep_last ? '0 : r + 1'b1;
      end else begin
        c <= c + 1'b1;
      end
    end else begin
      c <= '0;
      r <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and strobes, decoded from registered state only (write_in also
  // looks at the live job offer so the input buffer loads in the accept cycle).
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_ready = 1'b0;
    accept    = 1'b0;
    write_in  = 1'b0;
    rotate_in = 1'b0;
    zero_out  = 1'b0;
    write_out = 1'b0;
    sweep_en  = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (rnn_out_ready) begin
          accept   = 1'b1;
          write_in = 1'b1;
          state_nx = S_ZERO;
        end
      end
      S_ZERO: begin
        zero_out = 1'b1;
        state_nx = S_SWEEP;
      end
      S_SWEEP: begin
        rotate_in = 1'b1;
        write_out = 1'b1;
        sweep_en  = 1'b1;
        if (sweep_last) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        out_ready = 1'b1;
        if (bcau_in_ready) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-lane coordinates: lane i reads rows i*ROWS_PER_LANE + r, column c.
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      localparam logic [SEL_W-1:0] ROW_BASE = SEL_W'(i * ROWS_PER_LANE);
      assign row_sel[i] = sweep_en ? (ROW_BASE + r) : '0;
      assign col_sel[i] = sweep_en ? c : '0;
    end
  endgenerate

endmodule
`default_nettype wire
